// File: rtl/ethernet_axil_pkg.sv
// ---------------------------------------------------------------------------
// ethernet_axil_pkg : shared types for the AXI4-Lite to controller bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ethernet_axil_pkg;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_ISSUE   = 3'd1,
    WR_RESP    = 3'd2,
    RD_ISSUE   = 3'd3,
    RD_CAPTURE = 3'd4,
    RD_RESP    = 3'd5
  } state_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/ethernet_axil_strb_decode.sv
// ---------------------------------------------------------------------------
// ethernet_axil_strb_decode : WSTRB -> {legal, log2 size, lowest byte offset}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ethernet_axil_strb_decode #(
  parameter  int data_width_p  = 32,
  localparam int bytes_lp      = data_width_p / 8,
  localparam int ofs_width_lp  = $clog2(bytes_lp),
  localparam int size_width_lp = $clog2(ofs_width_lp + 1)
) (
  input  logic [bytes_lp-1:0]      wstrb_i,
  output logic                     legal_o,
  output logic [size_width_lp-1:0] size_o,
  output logic [ofs_width_lp-1:0]  ofs_o
);

  int                  w_lo;
  int                  w_cnt;
  int                  w_size;
  logic                w_pow2;
  logic [bytes_lp-1:0] w_mask;

  // Legal means one naturally aligned, contiguous, power-of-two run of bytes.
  always_comb begin
    w_lo  = bytes_lp;
    w_cnt = 0;
    for (int i = bytes_lp - 1; i >= 0; i--) begin
      if (wstrb_i[i]) w_lo = i;
    end
    for (int i = 0; i < bytes_lp; i++) begin
      w_cnt = w_cnt + int'(wstrb_i[i]);
    end
    for (int i = 0; i < bytes_lp; i++) begin
      w_mask[i] = (i >= w_lo) && (i < w_lo + w_cnt);
    end
    w_pow2 = (w_cnt == 1) || (w_cnt == 2) || (w_cnt == 4) || (w_cnt == 8);
    case (w_cnt)
      2:       w_size = 1;
      4:       w_size = 2;
      8:       w_size = 3;
      default: w_size = 0;
    endcase
    legal_o = w_pow2 && ((w_lo & (w_cnt - 1)) == 0) && (wstrb_i == w_mask);
    size_o  = size_width_lp'(w_size);
    ofs_o   = ofs_width_lp'(w_lo);
  end

endmodule

`default_nettype wire

// File: rtl/ethernet_axil_bridge.sv
// ---------------------------------------------------------------------------
// ethernet_axil_bridge : AXI4-Lite slave to ethernet controller register port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ethernet_axil_bridge
  import ethernet_axil_pkg::*;
#(
  parameter  int data_width_p      = 32,
  parameter  int axil_addr_width_p = 32,
  localparam int addr_width_lp     = 14,
  localparam int bytes_lp          = data_width_p / 8,
  localparam int ofs_width_lp      = $clog2(bytes_lp),
  localparam int size_width_lp     = $clog2(ofs_width_lp + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic                         s_axil_awvalid_i,
  output logic                         s_axil_awready_o,
  input  logic [data_width_p-1:0]      s_axil_wdata_i,
  input  logic [bytes_lp-1:0]          s_axil_wstrb_i,
  input  logic                         s_axil_wvalid_i,
  output logic                         s_axil_wready_o,
  output logic [1:0]                   s_axil_bresp_o,
  output logic                         s_axil_bvalid_o,
  input  logic                         s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic                         s_axil_arvalid_i,
  output logic                         s_axil_arready_o,
  output logic [data_width_p-1:0]      s_axil_rdata_o,
  output logic [1:0]                   s_axil_rresp_o,
  output logic                         s_axil_rvalid_o,
  input  logic                         s_axil_rready_i,

  output logic [addr_width_lp-1:0]     addr_o,
  output logic                         write_en_o,
  output logic                         read_en_o,
  output logic [size_width_lp-1:0]     op_size_o,
  output logic [data_width_p-1:0]      write_data_o,
  input  logic [data_width_p-1:0]      read_data_i
);

  state_e                                r_state;
  grant_e                                r_grant;
  logic                                  r_live;
  logic                                  r_aw_full;
  logic                                  r_w_full;
  logic [addr_width_lp-ofs_width_lp-1:0] r_awaddr_word;
  logic [data_width_p-1:0]               r_wdata;
  logic [bytes_lp-1:0]                   r_wstrb;
  logic                                  r_legal;
  logic                                  r_slverr;
  logic [addr_width_lp-1:0]              r_addr;
  logic [size_width_lp-1:0]              r_size;
  logic [data_width_p-1:0]               r_wr_data;
  logic [data_width_p-1:0]               r_rdata;

  logic                                  w_legal;
  logic [size_width_lp-1:0]              w_size;
  logic [ofs_width_lp-1:0]               w_ofs;
  logic                                  w_idle;
  logic                                  w_wr_rdy;
  logic                                  w_aw_hs;
  logic                                  w_w_hs;
  logic                                  w_ar_hs;
  logic                                  w_wr_go;
  logic                                  w_unused_addr;

  ethernet_axil_strb_decode #(
    .data_width_p(data_width_p)
  ) u_strb_decode (
    .wstrb_i (r_wstrb),
    .legal_o (w_legal),
    .size_o  (w_size),
    .ofs_o   (w_ofs)
  );

  // r_live keeps every ready low until the first clock after reset release.
  assign w_idle           = r_live && (r_state == IDLE);
  assign w_wr_rdy         = r_aw_full && r_w_full;
  assign s_axil_awready_o = w_idle && !r_aw_full;
  assign s_axil_wready_o  = w_idle && !r_w_full;
  assign s_axil_arready_o = w_idle && !(w_wr_rdy && (r_grant == WR));
  assign w_aw_hs          = s_axil_awvalid_i && s_axil_awready_o;
  assign w_w_hs           = s_axil_wvalid_i && s_axil_wready_o;
  assign w_ar_hs          = s_axil_arvalid_i && s_axil_arready_o;
  assign w_wr_go          = w_idle && w_wr_rdy && !w_ar_hs;

  assign write_en_o       = (r_state == WR_ISSUE) && r_legal;
  assign read_en_o        = (r_state == RD_ISSUE);
  assign addr_o           = r_addr;
  assign op_size_o        = r_size;
  assign write_data_o     = r_wr_data;
  assign s_axil_bvalid_o  = (r_state == WR_RESP);
  assign s_axil_bresp_o   = r_slverr ? c_resp_slverr : c_resp_okay;
  assign s_axil_rvalid_o  = (r_state == RD_RESP);
  assign s_axil_rresp_o   = c_resp_okay;
  assign s_axil_rdata_o   = r_rdata;

  // Address bits above the controller window and below word granularity are dropped.
  assign w_unused_addr    = ^{s_axil_awaddr_i, s_axil_araddr_i};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= IDLE;
      r_grant       <= WR;
      r_live        <= 1'b0;
      r_aw_full     <= 1'b0;
      r_w_full      <= 1'b0;
      r_awaddr_word <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_legal       <= 1'b0;
      r_slverr      <= 1'b0;
      r_addr        <= '0;
      r_size        <= '0;
      r_wr_data     <= '0;
      r_rdata       <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_aw_hs) begin
        r_aw_full     <= 1'b1;
        r_awaddr_word <= s_axil_awaddr_i[addr_width_lp-1:ofs_width_lp];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axil_wdata_i;
        r_wstrb  <= s_axil_wstrb_i;
      end
      case (r_state)
        IDLE: begin
          // Grant points at the side not served last, so contention alternates.
          if (w_wr_go) begin
            r_state   <= WR_ISSUE;
            r_grant   <= RD;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_legal   <= w_legal;
            r_slverr  <= !w_legal;
            r_addr    <= {r_awaddr_word, w_ofs};
            r_size    <= w_size;
            r_wr_data <= r_wdata >> {w_ofs, 3'b000};
          end else if (w_ar_hs) begin
            r_state <= RD_ISSUE;
            r_grant <= WR;
            r_addr  <= {s_axil_araddr_i[addr_width_lp-1:ofs_width_lp], {ofs_width_lp{1'b0}}};
            r_size  <= size_width_lp'(ofs_width_lp);
          end
        end
        WR_ISSUE:   r_state <= WR_RESP;
        WR_RESP:    if (s_axil_bready_i) r_state <= IDLE;
        RD_ISSUE:   r_state <= RD_CAPTURE;
        RD_CAPTURE: begin
          r_rdata <= read_data_i;
          r_state <= RD_RESP;
        end
        RD_RESP:    if (s_axil_rready_i) r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
